// File: rtl/calc_chain.sv
// calc_chain: chained add/sub/shift-add-mul key calculator with sticky overflow.
// Optional `CALC_SIGNED_EN selects two's-complement operands and results.
module calc_chain #(
  parameter int KEY_W = 4,
  parameter int RES_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [KEY_W-1:0] KEY,
  input  logic [1:0]       OP,
  input  logic             EQUAL,
  input  logic             CLR,
  input  logic             EVENT,
  output logic [RES_W-1:0] RESULT,
  output logic [2:0]       STATE,
  output logic             BUSY,
  output logic             OVF,
  output logic             ERR
);

  localparam int PW = RES_W + KEY_W;
  localparam int CW = $clog2(KEY_W);
  localparam logic [CW-1:0] LAST = CW'(KEY_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OP    = 3'd1;
  localparam logic [2:0] S_OPND2 = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  logic [2:0]       state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [KEY_W-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;

  logic [RES_W-1:0] key_ext;
  logic [RES_W:0]   sum;
  logic [RES_W:0]   diff;
  logic [PW-1:0]    prod_nx;
  logic [RES_W-1:0] acc_mag;
  logic [KEY_W-1:0] b_mag;
  logic             neg_init;
  logic             add_ovf;
  logic             sub_ovf;
  logic [RES_W-1:0] mul_res;
  logic             mul_ovf;

  assign sum     = {1'b0, acc_q} + {1'b0, b_q};
  assign diff    = {1'b0, acc_q} - {1'b0, b_q};
  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);

`ifdef CALC_SIGNED_EN
  localparam logic [PW-1:0] HALF = PW'(1) << (RES_W - 1);
  logic sa, sb;
  assign sa       = acc_q[RES_W-1];
  assign sb       = b_q[RES_W-1];
  assign key_ext  = {{(RES_W-KEY_W){KEY[KEY_W-1]}}, KEY};
  assign add_ovf  = (sa == sb) && (sum[RES_W-1] != sa);
  assign sub_ovf  = (sa != sb) && (diff[RES_W-1] != sa);
  assign acc_mag  = sa ? -acc_q : acc_q;
  assign b_mag    = sb ? -b_q[KEY_W-1:0] : b_q[KEY_W-1:0];
  assign neg_init = sa ^ sb;
  // Multiply magnitudes, then restore the sign on the final step.
  assign mul_res  = neg_q ? -prod_nx[RES_W-1:0] : prod_nx[RES_W-1:0];
  assign mul_ovf  = neg_q ? (prod_nx > HALF) : (prod_nx >= HALF);
`else
  assign key_ext  = {{(RES_W-KEY_W){1'b0}}, KEY};
  assign add_ovf  = sum[RES_W];
  assign sub_ovf  = diff[RES_W];
  assign acc_mag  = acc_q;
  assign b_mag    = b_q[KEY_W-1:0];
  assign neg_init = 1'b0;
  assign mul_res  = prod_nx[RES_W-1:0];
  assign mul_ovf  = |prod_nx[PW-1:RES_W];
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: if (EVENT) begin
        acc_d   = key_ext;
        ovf_d   = 1'b0;
        state_d = S_OP;
      end
      S_OP: if (EVENT) begin
        op_d    = OP;
        state_d = (OP == OP_BAD) ? S_ERR : S_OPND2;
      end
      S_OPND2: if (EVENT) begin
        b_d     = key_ext;
        state_d = S_WAIT;
      end
      S_WAIT: if (EVENT && EQUAL) begin
        mcand_d  = PW'(acc_mag);
        mplier_d = b_mag;
        prod_d   = '0;
        neg_d    = neg_init;
        cnt_d    = '0;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          prod_d   = prod_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            acc_d   = mul_res;
            res_d   = mul_res;
            ovf_d   = ovf_q | mul_ovf;
            state_d = S_DONE;
          end
        end else if (op_q == OP_SUB) begin
          acc_d   = diff[RES_W-1:0];
          res_d   = diff[RES_W-1:0];
          ovf_d   = ovf_q | sub_ovf;
          state_d = S_DONE;
        end else begin
          acc_d   = sum[RES_W-1:0];
          res_d   = sum[RES_W-1:0];
          ovf_d   = ovf_q | add_ovf;
          state_d = S_DONE;
        end
      end
      S_DONE: if (EVENT && !EQUAL) begin
        op_d    = OP;
        state_d = (OP == OP_BAD) ? S_ERR : S_OPND2;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else if (CLR) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
    end
  end

  assign RESULT = res_q;
  assign STATE  = state_q;
  assign BUSY   = (state_q == S_EXEC);
  assign ERR    = (state_q == S_ERR);
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_calc_chain.sv
// tb_calc_chain: directed vectors with a result scoreboard for calc_chain.
// Expected results are queued at EQUAL and checked on each entry to S_DONE.
module tb_calc_chain;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] KEY = '0;
  logic [1:0] OP = '0;
  logic       EQUAL = 1'b0;
  logic       CLR = 1'b0;
  logic       EVENT = 1'b0;
  logic [7:0] RESULT;
  logic [2:0] STATE;
  logic       BUSY;
  logic       OVF;
  logic       ERR;

  calc_chain #(.KEY_W(4), .RES_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .KEY(KEY), .OP(OP), .EQUAL(EQUAL),
    .CLR(CLR), .EVENT(EVENT), .RESULT(RESULT), .STATE(STATE),
    .BUSY(BUSY), .OVF(OVF), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         due;
    int         busy;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] BAD = 2'b11;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each entry to S_DONE pop and compare
  logic [2:0] prev_state = 3'd0;
  int busy_cnt = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (BUSY) busy_cnt++;
    if (STATE == 3'd5 && prev_state != 3'd5) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sb_result", int'(RESULT), int'(e.res));
        chk("sb_ovf", int'(OVF), int'(e.ovf));
        chk("sb_latency", cyc, e.due);
        chk("sb_busy_cycles", busy_cnt, e.busy);
      end
      busy_cnt = 0;
    end
    if (STATE == 3'd0) busy_cnt = 0;
    prev_state = STATE;
  end

  task automatic press(input logic [3:0] k, input logic [1:0] o,
                       input logic eq);
    @(negedge CLK);
    KEY = k; OP = o; EQUAL = eq; EVENT = 1'b1;
    @(negedge CLK);
    EVENT = 1'b0; EQUAL = 1'b0;
  endtask

  // EQUAL press that queues the expected completion
  task automatic exec(input logic [7:0] r, input logic v, input int lat,
                      input int busy);
    exp_t e;
    @(negedge CLK);
    e.res = r; e.ovf = v; e.due = cyc + lat; e.busy = busy;
    q.push_back(e);
    EQUAL = 1'b1; EVENT = 1'b1;
    @(negedge CLK);
    EVENT = 1'b0; EQUAL = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (STATE != 3'd5 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (STATE != 3'd5) chk("done_timeout", int'(STATE), 5);
  endtask

  task automatic clr_pulse();
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, int'(STATE), 0);
    chk({tag, "_result"}, int'(RESULT), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_ovf"}, int'(OVF), 0);
    chk({tag, "_err"}, int'(ERR), 0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // 3 + 5
    press(4'd3, ADD, 1'b0);
    press(4'd0, ADD, 1'b0);
    press(4'd5, ADD, 1'b0);
    exec(8'd8, 1'b0, 2, 1);
    wait_done();
    chk("t1_state", int'(STATE), 5);

    // 15 * 15
    clr_pulse();
    chk("clr_result", int'(RESULT), 0);
    press(4'd15, ADD, 1'b0);
    press(4'd0, MUL, 1'b0);
    press(4'd15, ADD, 1'b0);
    exec(8'd225, 1'b0, 5, 4);
    wait_done();

    // chained adds, wrap sets sticky overflow
    press(4'd0, ADD, 1'b0);
    press(4'd15, ADD, 1'b0);
    exec(8'd240, 1'b0, 2, 1);
    wait_done();
    press(4'd0, ADD, 1'b0);
    press(4'd15, ADD, 1'b0);
    exec(8'd255, 1'b0, 2, 1);
    wait_done();
    press(4'd0, ADD, 1'b0);
    press(4'd1, ADD, 1'b0);
    exec(8'd0, 1'b1, 2, 1);
    wait_done();
    press(4'd0, ADD, 1'b0);
    press(4'd2, ADD, 1'b0);
    exec(8'd2, 1'b1, 2, 1);
    wait_done();
    // EQUAL in S_DONE does not repeat
    press(4'd0, ADD, 1'b1);
    repeat (3) @(negedge CLK);
    chk("done_eq_state", int'(STATE), 5);
    chk("done_eq_result", int'(RESULT), 2);

    // 2 - 5
    clr_pulse();
    press(4'd2, ADD, 1'b0);
    press(4'd0, SUB, 1'b0);
    press(4'd5, ADD, 1'b0);
`ifdef CALC_SIGNED_EN
    exec(8'hFD, 1'b0, 2, 1);
`else
    exec(8'hFD, 1'b1, 2, 1);
`endif
    wait_done();

    // illegal chained op keeps RESULT
    press(4'd0, BAD, 1'b0);
    chk("chain_err_state", int'(STATE), 6);
    chk("chain_err_result", int'(RESULT), 8'hFD);
    repeat (3) press(4'd9, ADD, 1'b1);
    chk("err_hold_state", int'(STATE), 6);
    chk("err_hold_result", int'(RESULT), 8'hFD);
    chk("err_flag", int'(ERR), 1);
    clr_pulse();
    chk("err_clr_state", int'(STATE), 0);
    chk("err_clr_err", int'(ERR), 0);
    press(4'd7, ADD, 1'b0);
    press(4'd0, BAD, 1'b0);
    chk("t5_state", int'(STATE), 6);
    chk("t5_err", int'(ERR), 1);
    chk("t5_result", int'(RESULT), 0);
    clr_pulse();
    chk_zero("t5_clr");

    // async reset mid-multiply
    press(4'd3, ADD, 1'b0);
    press(4'd0, ADD, 1'b0);
    press(4'd4, ADD, 1'b0);
    exec(8'd7, 1'b0, 2, 1);
    wait_done();
    press(4'd0, MUL, 1'b0);
    press(4'd5, ADD, 1'b0);
    press(4'd0, ADD, 1'b1);
    @(negedge CLK);
    chk("mul_busy", int'(BUSY), 1);
    #2 RST_N = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge CLK);
    RST_N = 1'b1;

    // CLR mid-multiply
    press(4'd3, ADD, 1'b0);
    press(4'd0, ADD, 1'b0);
    press(4'd4, ADD, 1'b0);
    exec(8'd7, 1'b0, 2, 1);
    wait_done();
    press(4'd0, MUL, 1'b0);
    press(4'd5, ADD, 1'b0);
    press(4'd0, ADD, 1'b1);
    chk("mul_busy2", int'(BUSY), 1);
    clr_pulse();
    chk_zero("exec_clr");

    repeat (8) @(negedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
